cmd_packet_rx: RTL and testbench
================================

Name: cmd_packet_rx

Overview:
Upstream framing stage for the command path. Takes the byte stream from the host link (UART RX strobe), finds packet boundaries and checks length and checksum. On a good packet it presents opcode, payload length and payload, with a one-cycle packet_ready pulse, to the command decoder. Malformed or stalled packets are dropped and reported on error strobes; the previously presented packet stays untouched.

Parameters:
MAX_PAYLOAD, 8, maximum payload bytes per packet (1..16)
TIMEOUT_CYCLES, 100000, CLK cycles allowed between consecutive bytes inside a packet before abort (>=2)
SYNC_BYTE, 8'hA5, packet start marker

Ports:
CLK  in  1  clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte, valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
packet_ready  out  1  one-cycle pulse: new good packet on opcode/payload_len/payload
opcode  out  8  opcode of last good packet
payload_len  out  5  payload byte count of last good packet
payload  out  MAX_PAYLOAD*8  payload of last good packet; byte 0 in bits [7:0]; unused bytes zero
err_chk  out  1  one-cycle pulse: checksum mismatch, packet dropped
err_len  out  1  one-cycle pulse: LEN > MAX_PAYLOAD, packet dropped
err_timeout  out  1  one-cycle pulse: inter-byte timeout, packet dropped

Behaviour:
- Interface: reset rst, synchronous, active-high; clock CLK.
- Frame format: SYNC_BYTE, OPCODE, LEN, LEN payload bytes, CHK.
  - CHK = XOR of OPCODE, LEN and all payload bytes.
- Reset values: every output 0; state IDLE; working buffer and timeout counter cleared.
- States and transitions (each advance happens only on a cycle with rx_valid=1):
  - IDLE: byte == SYNC_BYTE -> OPC; any other byte is ignored.
  - OPC: capture opcode, init running XOR with it -> LEN.
  - LEN: if LEN > MAX_PAYLOAD: err_len pulse next cycle, -> IDLE. If LEN == 0 -> CHK. Otherwise -> PAYLOAD, byte index 0. LEN is XORed into the running checksum.
  - PAYLOAD: store byte at index, XOR into checksum, increment index; after byte LEN-1 -> CHK.
  - CHK: if byte == running XOR, commit; otherwise err_chk pulse. Both cases -> IDLE.
- SYNC_BYTE inside OPC/LEN/PAYLOAD/CHK is ordinary data; no resync mid-packet.
- Working buffer is separate from the output registers. opcode, payload_len and payload change only on commit; they hold otherwise, including after errors.
- Commit:
  - Output registers load in the cycle after the CHK byte strobe; packet_ready pulses high in that same cycle.
  - Latency is 1 cycle from the CHK rx_valid.
  - Payload bytes at index >= LEN are driven zero.
- packet_ready is never held or retried. Downstream must sample it on the pulse; there is no backpressure.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle with rx_valid=0.
  - The counter clears on every accepted byte and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with rx_valid=0: err_timeout pulse next cycle, -> IDLE.
  - A byte arriving in the expiry cycle wins: it is accepted and the counter clears.
- Error and ready pulses are mutually exclusive; at most one output strobe per cycle.
- rst asserted mid-packet: working buffer discarded, state IDLE, outputs zeroed. No error pulse is generated.
- A new SYNC can be accepted in the cycle immediately after the CHK byte (back-to-back packets).

Optional Feature:
CMD_PACKET_RX_STATS_EN
- Defined:
  - Adds outputs good_cnt[15:0] and err_cnt[15:0].
  - good_cnt increments on each packet_ready; err_cnt increments on each err_chk, err_len or err_timeout.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Good packet: A5 03 02 11 22 32 -> packet_ready pulse 1 cycle after the 32 byte; opcode=03, payload_len=2, payload[15:0]=16'h2211, upper bits 0.
- Bad checksum: after the good packet, send A5 05 01 44 00 -> err_chk pulse, no packet_ready; opcode stays 03, payload[15:0] stays 2211.
- Zero length and leading noise: 00 FF A5 01 00 01 -> noise ignored; packet_ready with opcode=01, payload_len=0, payload all zero.
- Oversize length (MAX_PAYLOAD=8): A5 05 09 -> err_len pulse; then A5 02 00 02 -> packet_ready with opcode=02.
- Timeout (TIMEOUT_CYCLES=16): A5 03 then idle -> err_timeout pulse; state back in IDLE. Next, A5 06 00 06 with a 15-cycle gap between bytes -> no timeout; packet_ready with opcode=06.
- Reset mid-packet: A5 04 02 11, assert rst 1 cycle, then A5 04 00 04 -> no error pulse; single packet_ready with opcode=04, payload_len=0; with the stats macro defined, good_cnt=1, err_cnt=0.

Source files
------------

// File: rtl/cmd_packet_rx.sv
// rtl/cmd_packet_rx.sv - host-link packet framer: sync, length and checksum check, commit to decoder
// Optional statistics counters enabled by defining CMD_PACKET_RX_STATS_EN.
module cmd_packet_rx #(
   parameter int          MAX_PAYLOAD    = 8,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     packet_ready,
   output logic [7:0]               opcode,
   output logic [4:0]               payload_len,
   output logic [MAX_PAYLOAD*8-1:0] payload,
   output logic                     err_chk,
   output logic                     err_len,
`ifdef CMD_PACKET_RX_STATS_EN
   output logic [15:0]              good_cnt,
   output logic [15:0]              err_cnt,
`endif
   output logic                     err_timeout
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_OPC, S_LEN, S_PAYLOAD, S_CHK} state_t;

   state_t                   state_q, state_d;
   logic [7:0]               wopc_q, wopc_d;
   logic [4:0]               len_q, len_d;
   logic [4:0]               idx_q, idx_d;
   logic [7:0]               xor_q, xor_d;
   logic [MAX_PAYLOAD*8-1:0] buf_q, buf_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic [7:0]               opcode_q, opcode_d;
   logic [4:0]               plen_q, plen_d;
   logic [MAX_PAYLOAD*8-1:0] pay_q, pay_d;
   logic                     rdy_q, rdy_d;
   logic                     echk_q, echk_d;
   logic                     elen_q, elen_d;
   logic                     etmo_q, etmo_d;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wopc_q   <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         xor_q    <= '0;
         buf_q    <= '0;
         tmo_q    <= '0;
         opcode_q <= '0;
         plen_q   <= '0;
         pay_q    <= '0;
         rdy_q    <= 1'b0;
         echk_q   <= 1'b0;
         elen_q   <= 1'b0;
         etmo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wopc_q   <= wopc_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         xor_q    <= xor_d;
         buf_q    <= buf_d;
         tmo_q    <= tmo_d;
         opcode_q <= opcode_d;
         plen_q   <= plen_d;
         pay_q    <= pay_d;
         rdy_q    <= rdy_d;
         echk_q   <= echk_d;
         elen_q   <= elen_d;
         etmo_q   <= etmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wopc_d   = wopc_q;
      len_d    = len_q;
      idx_d    = idx_q;
      xor_d    = xor_q;
      buf_d    = buf_q;
      tmo_d    = tmo_q;
      opcode_d = opcode_q;
      plen_d   = plen_q;
      pay_d    = pay_q;
      rdy_d    = 1'b0;
      echk_d   = 1'b0;
      elen_d   = 1'b0;
      etmo_d   = 1'b0;
      if (state_q == S_IDLE) begin
         tmo_d = '0;
         if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = S_OPC;
            // Cleared here so payload bytes beyond LEN commit as zero
            buf_d   = '0;
         end
      end else if (!rx_valid) begin
         // A byte in the expiry cycle takes the other branch and wins
         if (tmo_q == TMO_LAST) begin
            etmo_d  = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end else begin
         tmo_d = '0;
         case (state_q)
            S_OPC: begin
               wopc_d  = rx_data;
               xor_d   = rx_data;
               state_d = S_LEN;
            end
            S_LEN: begin
               xor_d = xor_q ^ rx_data;
               len_d = rx_data[4:0];
               idx_d = '0;
               if (rx_data > 8'(MAX_PAYLOAD)) begin
                  elen_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (rx_data == 8'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               for (int i = 0; i < MAX_PAYLOAD; i++) begin
                  if (idx_q == 5'(i)) buf_d[i*8 +: 8] = rx_data;
               end
               xor_d = xor_q ^ rx_data;
               idx_d = idx_q + 5'd1;
               if (idx_q == len_q - 5'd1) state_d = S_CHK;
            end
            S_CHK: begin
               if (rx_data == xor_q) begin
                  opcode_d = wopc_q;
                  plen_d   = len_q;
                  pay_d    = buf_q;
                  rdy_d    = 1'b1;
               end else begin
                  echk_d = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign packet_ready = rdy_q;
   assign opcode       = opcode_q;
   assign payload_len  = plen_q;
   assign payload      = pay_q;
   assign err_chk      = echk_q;
   assign err_len      = elen_q;
   assign err_timeout  = etmo_q;

`ifdef CMD_PACKET_RX_STATS_EN
   logic [15:0] good_q, errc_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         good_q <= '0;
         errc_q <= '0;
      end else begin
         if (rdy_q && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
         if ((echk_q || elen_q || etmo_q) && errc_q != 16'hFFFF) errc_q <= errc_q + 16'd1;
      end
   end

   assign good_cnt = good_q;
   assign err_cnt  = errc_q;
`endif

endmodule

// File: tb/tb_cmd_packet_rx.sv
// tb/tb_cmd_packet_rx.sv - directed self-checking bench for cmd_packet_rx
module tb_cmd_packet_rx;

   logic        CLK = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        packet_ready;
   logic [7:0]  opcode;
   logic [4:0]  payload_len;
   logic [63:0] payload;
   logic        err_chk, err_len, err_timeout;
`ifdef CMD_PACKET_RX_STATS_EN
   logic [15:0] good_cnt, err_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int n_rdy = 0, n_chk = 0, n_len = 0, n_tmo = 0;

   cmd_packet_rx #(.MAX_PAYLOAD(8), .TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
      .CLK(CLK), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .packet_ready(packet_ready), .opcode(opcode), .payload_len(payload_len),
      .payload(payload), .err_chk(err_chk), .err_len(err_len),
`ifdef CMD_PACKET_RX_STATS_EN
      .good_cnt(good_cnt), .err_cnt(err_cnt),
`endif
      .err_timeout(err_timeout)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (packet_ready) n_rdy++;
      if (err_chk) n_chk++;
      if (err_len) n_len++;
      if (err_timeout) n_tmo++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) tick();
      chk("reset_ready", 64'(packet_ready), 64'd0);
      chk("reset_opcode", 64'(opcode), 64'd0);
      chk("reset_len", 64'(payload_len), 64'd0);
      chk("reset_payload", payload, 64'd0);
      chk("reset_errs", 64'({err_chk, err_len, err_timeout}), 64'd0);
      rst = 1'b0;
      tick();

      // good packet
      send(8'hA5); send(8'h03); send(8'h02); send(8'h11); send(8'h22); send(8'h32);
      chk("good_ready", 64'(packet_ready), 64'd1);
      chk("good_opcode", 64'(opcode), 64'h03);
      chk("good_len", 64'(payload_len), 64'd2);
      chk("good_payload", payload, 64'h2211);
      tick();
      chk("good_ready_pulse", 64'(packet_ready), 64'd0);

      // bad checksum
      send(8'hA5); send(8'h05); send(8'h01); send(8'h44); send(8'h00);
      chk("badchk_err", 64'(err_chk), 64'd1);
      chk("badchk_ready", 64'(packet_ready), 64'd0);
      chk("badchk_opcode_hold", 64'(opcode), 64'h03);
      chk("badchk_payload_hold", payload, 64'h2211);
      tick();
      chk("badchk_err_pulse", 64'(err_chk), 64'd0);

      // noise then zero-length packet
      send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
      chk("zlen_ready", 64'(packet_ready), 64'd1);
      chk("zlen_opcode", 64'(opcode), 64'h01);
      chk("zlen_len", 64'(payload_len), 64'd0);
      chk("zlen_payload", payload, 64'd0);
      tick();

      // oversize length
      send(8'hA5); send(8'h05); send(8'h09);
      chk("oversize_err", 64'(err_len), 64'd1);
      chk("oversize_opcode_hold", 64'(opcode), 64'h01);
      send(8'hA5); send(8'h02); send(8'h00); send(8'h02);
      chk("after_oversize_ready", 64'(packet_ready), 64'd1);
      chk("after_oversize_opcode", 64'(opcode), 64'h02);
      tick();

      // timeout: expires on the 16th idle cycle after the last byte
      send(8'hA5); send(8'h03);
      n = 0;
      while (n < 40 && err_timeout !== 1'b1) begin
         tick();
         n++;
      end
      chk("timeout_latency", 64'(n), 64'd16);
      tick();
      // 15-cycle gaps stay inside the window
      send(8'hA5); repeat (15) tick();
      send(8'h06); repeat (15) tick();
      send(8'h00); repeat (15) tick();
      send(8'h06);
      chk("gap15_ready", 64'(packet_ready), 64'd1);
      chk("gap15_opcode", 64'(opcode), 64'h06);
      tick();
      chk("timeout_count", 64'(n_tmo), 64'd1);

      // reset mid-packet
      send(8'hA5); send(8'h04); send(8'h02); send(8'h11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_opcode_zero", 64'(opcode), 64'd0);
      send(8'hA5); send(8'h04); send(8'h00); send(8'h04);
      chk("midrst_ready", 64'(packet_ready), 64'd1);
      chk("midrst_opcode", 64'(opcode), 64'h04);
      chk("midrst_len", 64'(payload_len), 64'd0);
      tick();
      chk("midrst_ready_pulse", 64'(packet_ready), 64'd0);
`ifdef CMD_PACKET_RX_STATS_EN
      chk("stats_good", 64'(good_cnt), 64'd1);
      chk("stats_err", 64'(err_cnt), 64'd0);
`endif

      // back-to-back packets
      send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
      chk("b2b_first_ready", 64'(packet_ready), 64'd1);
      send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
      chk("b2b_second_ready", 64'(packet_ready), 64'd1);
      chk("b2b_second_opcode", 64'(opcode), 64'h07);
      tick();

      // full-size payload
      send(8'hA5); send(8'h09); send(8'h08);
      for (int i = 1; i <= 8; i++) send(8'(i));
      send(8'h09);
      chk("full_ready", 64'(packet_ready), 64'd1);
      chk("full_len", 64'(payload_len), 64'd8);
      chk("full_payload", payload, 64'h0807060504030201);
      tick();
      tick();

      chk("total_ready", 64'(n_rdy), 64'd8);
      chk("total_err_chk", 64'(n_chk), 64'd1);
      chk("total_err_len", 64'(n_len), 64'd1);
      chk("total_err_tmo", 64'(n_tmo), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
